// File: rtl/reorder_buffer_if.sv
// Reorder buffer handshake bundle: allocate, complete and retire lanes.
// master drives allocation/completion, slave is the ROB itself.
interface reorder_buffer_if #(
  parameter int MACHINE_WIDTH = 2,
  parameter int ALU_NUM = 2,
  parameter int ROB_DEPTH = 16
);
  localparam int MW = MACHINE_WIDTH;
  localparam int AW = $clog2(ROB_DEPTH);

  logic [MW-1:0]             alloc_valid;
  logic [MW-1:0][4:0]        alloc_dst;
  logic [MW-1:0][31:0]       alloc_pcplus8;
  logic [MW-1:0]             alloc_exc_valid;
  logic [MW-1:0][4:0]        alloc_exc_code;
  logic [MW-1:0]             alloc_is_branch;
  logic                      alloc_ready;
  logic [MW-1:0][AW-1:0]     alloc_rob_addr;

  logic [ALU_NUM-1:0]         cmpl_valid;
  logic [ALU_NUM-1:0][AW-1:0] cmpl_rob_addr;
  logic [ALU_NUM-1:0][31:0]   cmpl_data;
  logic [ALU_NUM-1:0]         cmpl_taken;
  logic [ALU_NUM-1:0][31:0]   cmpl_target;

  logic [MW-1:0]         retire_valid;
  logic [MW-1:0][4:0]    retire_dst;
  logic [MW-1:0][31:0]   retire_data;
  logic [MW-1:0][AW-1:0] retire_rob_addr;
  logic                  branch_taken;
  logic [31:0]           pcbranch;
  logic                  exc_valid;
  logic [31:0]           exc_pc;
  logic [4:0]            exc_code;

  modport master (
    output alloc_valid, alloc_dst, alloc_pcplus8,
    output alloc_exc_valid, alloc_exc_code,
    output alloc_is_branch,
    input  alloc_ready, alloc_rob_addr,
    output cmpl_valid, cmpl_rob_addr, cmpl_data,
    output cmpl_taken, cmpl_target,
    input  retire_valid, retire_dst, retire_data,
    input  retire_rob_addr,
    input  branch_taken, pcbranch,
    input  exc_valid, exc_pc, exc_code
  );

  modport slave (
    input  alloc_valid, alloc_dst, alloc_pcplus8,
    input  alloc_exc_valid, alloc_exc_code,
    input  alloc_is_branch,
    output alloc_ready, alloc_rob_addr,
    input  cmpl_valid, cmpl_rob_addr, cmpl_data,
    input  cmpl_taken, cmpl_target,
    output retire_valid, retire_dst, retire_data,
    output retire_rob_addr,
    output branch_taken, pcbranch,
    output exc_valid, exc_pc, exc_code
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer with delay-slot aware retirement,
// branch redirection and precise exceptions.
module reorder_buffer #(
  parameter int MACHINE_WIDTH = 2,
  parameter int ALU_NUM = 2,
  parameter int ROB_DEPTH = 16
) (
  input logic clk,
  input logic resetn,
  input logic flush,
  reorder_buffer_if.slave rob
);
  localparam int MW = MACHINE_WIDTH;
  localparam int AW = $clog2(ROB_DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  dst;
    logic [31:0] pcplus8;
    logic        exc;
    logic [4:0]  code;
    logic        br;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef enum logic {NORMAL, WAIT_DS} state_t;

  ent_t        ent_q [ROB_DEPTH];
  ent_t        ent_d [ROB_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  state_t      state_q, state_d;
  logic        ds_taken_q, ds_taken_d;
  logic [31:0] ds_target_q, ds_target_d;

  logic [PW-1:0] count;
  logic [AW-1:0] hidx;
  logic [AW-1:0] lane_idx [MW];
  logic [AW-1:0] alloc_idx [MW];

  assign count = tail_q - head_q;
  assign hidx = head_q[AW-1:0];
  assign rob.alloc_ready = (ROB_DEPTH - int'(count)) >= MW;

  always_comb begin
    for (int i = 0; i < MW; i++) begin
      lane_idx[i] = hidx + AW'(i);
      alloc_idx[i] = tail_q[AW-1:0] + AW'(i);
      rob.alloc_rob_addr[i] = alloc_idx[i];
    end
  end

  logic [MW-1:0] ret;
  logic          exc, redirect, enter_ds, ds_done;
  logic          pend, stop, br_tk;
  logic [31:0]   redir_pc, br_tgt;
  ent_t          e, exc_ent;

  // In-order scan; a branch holds the scan open for exactly one more lane.
  always_comb begin
    ret = '0;
    exc = 1'b0;
    exc_ent = '0;
    redirect = 1'b0;
    redir_pc = '0;
    enter_ds = 1'b0;
    ds_done = 1'b0;
    pend = 1'b0;
    br_tk = 1'b0;
    br_tgt = '0;
    stop = flush;
    e = '0;
    if (state_q == WAIT_DS) begin
      e = ent_q[hidx];
      if (!stop && e.valid && e.done) begin
        if (e.exc) begin
          exc = 1'b1;
          exc_ent = e;
        end else begin
          ret[0] = 1'b1;
          ds_done = 1'b1;
          redirect = ds_taken_q;
          redir_pc = ds_target_q;
        end
      end
    end else begin
      for (int i = 0; i < MW; i++) begin
        e = ent_q[lane_idx[i]];
        if (!stop) begin
          if (pend) begin
            pend = 1'b0;
            stop = 1'b1;
            if (e.valid && e.done && !e.exc) begin
              ret[i] = 1'b1;
              redirect = br_tk;
              redir_pc = br_tgt;
            end else begin
              enter_ds = 1'b1;
            end
          end else if (!e.valid || !e.done) begin
            stop = 1'b1;
          end else if (e.exc) begin
            if (i == 0) begin
              exc = 1'b1;
              exc_ent = e;
            end
            stop = 1'b1;
          end else begin
            ret[i] = 1'b1;
            if (e.br) begin
              pend = 1'b1;
              br_tk = e.taken;
              br_tgt = e.target;
            end
          end
        end
      end
      if (pend) enter_ds = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < MW; i++) begin
      rob.retire_valid[i] = ret[i];
      rob.retire_dst[i] = ret[i] ? ent_q[lane_idx[i]].dst : '0;
      rob.retire_data[i] = ret[i] ? ent_q[lane_idx[i]].data : '0;
      rob.retire_rob_addr[i] = ret[i] ? lane_idx[i] : '0;
    end
    rob.branch_taken = redirect;
    rob.pcbranch = redirect ? redir_pc : '0;
    rob.exc_valid = exc;
    rob.exc_pc = exc ? exc_ent.pcplus8 - 32'd8 : '0;
    rob.exc_code = exc ? exc_ent.code : '0;
  end

  logic [PW-1:0] nret, nalloc;
  logic [MW-1:0] alloc_go;
  logic          run;

  always_comb begin
    nret = '0;
    nalloc = '0;
    alloc_go = '0;
    run = rob.alloc_ready;
    for (int i = 0; i < MW; i++) begin
      nret = nret + PW'(ret[i]);
      run = run & rob.alloc_valid[i];
      alloc_go[i] = run;
      nalloc = nalloc + PW'(run);
    end
  end

  always_comb begin
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    state_d = state_q;
    ds_taken_d = ds_taken_q;
    ds_target_d = ds_target_q;
    if (flush || exc) begin
      for (int j = 0; j < ROB_DEPTH; j++) begin
        ent_d[j].valid = 1'b0;
        ent_d[j].done = 1'b0;
      end
      state_d = NORMAL;
      if (flush) begin
        tail_d = head_q;
      end else begin
        head_d = head_q + PW'(1);
        tail_d = head_q + PW'(1);
      end
    end else begin
      // Descending so port 0 overwrites port 1 on a shared index.
      for (int p = ALU_NUM - 1; p >= 0; p--) begin
        if (rob.cmpl_valid[p]
            && ent_q[rob.cmpl_rob_addr[p]].valid
            && !ent_q[rob.cmpl_rob_addr[p]].done) begin
          ent_d[rob.cmpl_rob_addr[p]].done = 1'b1;
          ent_d[rob.cmpl_rob_addr[p]].data = rob.cmpl_data[p];
          ent_d[rob.cmpl_rob_addr[p]].taken = rob.cmpl_taken[p];
          ent_d[rob.cmpl_rob_addr[p]].target = rob.cmpl_target[p];
        end
      end
      for (int i = 0; i < MW; i++) begin
        if (ret[i]) begin
          ent_d[lane_idx[i]].valid = 1'b0;
          ent_d[lane_idx[i]].done = 1'b0;
        end
      end
      head_d = head_q + nret;
      if (enter_ds) begin
        state_d = WAIT_DS;
        ds_taken_d = br_tk;
        ds_target_d = br_tgt;
      end
      if (ds_done) state_d = NORMAL;
      if (redirect) begin
        for (int j = 0; j < ROB_DEPTH; j++) begin
          ent_d[j].valid = 1'b0;
          ent_d[j].done = 1'b0;
        end
        tail_d = head_d;
        state_d = NORMAL;
      end else begin
        for (int i = 0; i < MW; i++) begin
          if (alloc_go[i]) begin
            ent_d[alloc_idx[i]] = '0;
            ent_d[alloc_idx[i]].valid = 1'b1;
            ent_d[alloc_idx[i]].done = rob.alloc_exc_valid[i];
            ent_d[alloc_idx[i]].dst = rob.alloc_dst[i];
            ent_d[alloc_idx[i]].pcplus8 = rob.alloc_pcplus8[i];
            ent_d[alloc_idx[i]].exc = rob.alloc_exc_valid[i];
            ent_d[alloc_idx[i]].code = rob.alloc_exc_code[i];
            ent_d[alloc_idx[i]].br = rob.alloc_is_branch[i];
          end
        end
        tail_d = tail_q + nalloc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < ROB_DEPTH; j++) ent_q[j] <= '0;
      head_q <= '0;
      tail_q <= '0;
      state_q <= NORMAL;
      ds_taken_q <= 1'b0;
      ds_target_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      state_q <= state_d;
      ds_taken_q <= ds_taken_d;
      ds_target_q <= ds_target_d;
    end
  end
endmodule
